// File: rtl/execute_stage_pkg.sv
// Shared definitions for the EX stage: ISA opcodes, flag bit positions and
// the saturation limits used by the ALU.
package execute_stage_pkg;
  localparam logic [3:0] OP_ADD    = 4'h0;
  localparam logic [3:0] OP_SUB    = 4'h1;
  localparam logic [3:0] OP_XOR    = 4'h2;
  localparam logic [3:0] OP_RED    = 4'h3;
  localparam logic [3:0] OP_SLL    = 4'h4;
  localparam logic [3:0] OP_SRA    = 4'h5;
  localparam logic [3:0] OP_ROR    = 4'h6;
  localparam logic [3:0] OP_PADDSB = 4'h7;
  localparam logic [3:0] OP_LW     = 4'h8;
  localparam logic [3:0] OP_SW     = 4'h9;
  localparam logic [3:0] OP_LHB    = 4'hA;
  localparam logic [3:0] OP_LLB    = 4'hB;
  localparam logic [3:0] OP_B      = 4'hC;
  localparam logic [3:0] OP_BR     = 4'hD;
  localparam logic [3:0] OP_PCS    = 4'hE;
  localparam logic [3:0] OP_HLT    = 4'hF;

  localparam int FLG_Z = 2;
  localparam int FLG_V = 1;
  localparam int FLG_N = 0;

  localparam logic [15:0] SAT16_MAX = 16'h7FFF;
  localparam logic [15:0] SAT16_MIN = 16'h8000;
  localparam logic [3:0]  SAT4_MAX  = 4'h7;
  localparam logic [3:0]  SAT4_MIN  = 4'h8;
endpackage

// File: rtl/execute_stage_alu_16.sv
// Combinational 16-bit ALU / address unit; also reports which of the Z/V/N
// flags the opcode is allowed to write and their new values.
module alu_16
  import execute_stage_pkg::*;
(
  input  logic [3:0]  i_opcode,
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  input  logic [15:0] i_imm,
  output logic [15:0] o_result,
  output logic [2:0]  o_flags,
  output logic [2:0]  o_flag_wr_mask
);
  logic [16:0] w_sum, w_diff;
  logic        w_add_ovf, w_sub_ovf;
  logic [15:0] w_add_sat, w_sub_sat, w_sll, w_sra, w_ror, w_paddsb;
  logic [9:0]  w_red;

  // One extra sign bit: overflow shows up as the top two bits disagreeing.
  assign w_sum     = {i_a[15], i_a} + {i_b[15], i_b};
  assign w_diff    = {i_a[15], i_a} - {i_b[15], i_b};
  assign w_add_ovf = w_sum[16] ^ w_sum[15];
  assign w_sub_ovf = w_diff[16] ^ w_diff[15];
  assign w_add_sat = w_add_ovf ? (w_sum[16] ? SAT16_MIN : SAT16_MAX) : w_sum[15:0];
  assign w_sub_sat = w_sub_ovf ? (w_diff[16] ? SAT16_MIN : SAT16_MAX) : w_diff[15:0];

  assign w_red = {{2{i_a[15]}}, i_a[15:8]} + {{2{i_b[15]}}, i_b[15:8]}
               + {{2{i_a[7]}}, i_a[7:0]}   + {{2{i_b[7]}}, i_b[7:0]};

  assign w_sll = i_a << i_imm[3:0];
  assign w_sra = $signed(i_a) >>> i_imm[3:0];
  assign w_ror = (i_a >> i_imm[3:0]) | (i_a << (5'd16 - {1'b0, i_imm[3:0]}));

  for (genvar g = 0; g < 4; g++) begin : g_nib
    logic [4:0] w_ns;
    assign w_ns = {i_a[4*g+3], i_a[4*g +: 4]} + {i_b[4*g+3], i_b[4*g +: 4]};
    assign w_paddsb[4*g +: 4] = (w_ns[4] ^ w_ns[3]) ? (w_ns[4] ? SAT4_MIN : SAT4_MAX) : w_ns[3:0];
  end

  always_comb begin
    o_result       = i_a;
    o_flag_wr_mask = 3'b000;
    case (i_opcode)
      OP_ADD:    begin o_result = w_add_sat; o_flag_wr_mask = 3'b111; end
      OP_SUB:    begin o_result = w_sub_sat; o_flag_wr_mask = 3'b111; end
      OP_XOR:    begin o_result = i_a ^ i_b; o_flag_wr_mask[FLG_Z] = 1'b1; end
      OP_RED:    o_result = {{6{w_red[9]}}, w_red};
      OP_SLL:    begin o_result = w_sll; o_flag_wr_mask[FLG_Z] = 1'b1; end
      OP_SRA:    begin o_result = w_sra; o_flag_wr_mask[FLG_Z] = 1'b1; end
      OP_ROR:    begin o_result = w_ror; o_flag_wr_mask[FLG_Z] = 1'b1; end
      OP_PADDSB: o_result = w_paddsb;
      OP_LW, OP_SW: o_result = (i_a & 16'hFFFE) + (i_imm << 1);
      OP_LHB:    o_result = (i_a & 16'h00FF) | {i_imm[7:0], 8'h00};
      OP_LLB:    o_result = (i_a & 16'hFF00) | {8'h00, i_imm[7:0]};
      OP_B, OP_BR, OP_PCS, OP_HLT: o_result = i_a;
      default:   o_result = i_a;
    endcase
  end

  always_comb begin
    o_flags         = 3'b000;
    o_flags[FLG_Z]  = (o_result == 16'h0000);
    o_flags[FLG_V]  = (i_opcode == OP_SUB) ? w_sub_ovf : w_add_ovf;
    o_flags[FLG_N]  = o_result[15];
  end
endmodule

// File: rtl/execute_stage.sv
// EX stage: operand forwarding, ALU, Z/V/N flag register and the X/M pipeline
// register. Results land one edge after the op is presented; stall holds, flush wins.
module execute_stage
  import execute_stage_pkg::*;
#(
  parameter int DW = 16,
  parameter int RW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          stall_en,
  input  logic          flush,
  input  logic [3:0]    opcode_in,
  input  logic [DW-1:0] rd1_in,
  input  logic [DW-1:0] rd2_in,
  input  logic [DW-1:0] sign_ext_in,
  input  logic [RW-1:0] dstReg_in,
  input  logic [RW-1:0] srcReg1_in,
  input  logic [RW-1:0] srcReg2_in,
  input  logic          is_LLB_or_LHB_in,
  input  logic          regwrite_in,
  input  logic          memread_in,
  input  logic          memwrite_in,
  input  logic          memwb_regwrite,
  input  logic [RW-1:0] memwb_dstReg,
  input  logic [DW-1:0] memwb_data,
  output logic [DW-1:0] alu_result_out,
  output logic [DW-1:0] store_data_out,
  output logic [RW-1:0] dstReg_out,
  output logic          regwrite_out,
  output logic          memread_out,
  output logic          memwrite_out,
  output logic [2:0]    flags_out
);
  logic [DW-1:0] r_alu_result, r_store_data;
  logic [RW-1:0] r_dst;
  logic          r_regwrite, r_memread, r_memwrite;
  logic [2:0]    r_flags;

  logic [RW-1:0] w_src_a;
  logic          w_a_xm, w_a_mw, w_b_xm, w_b_mw;
  logic [DW-1:0] w_op_a, w_op_b, w_result;
  logic [2:0]    w_flags, w_mask;

  // For LLB/LHB the A operand is the old destination value.
  assign w_src_a = is_LLB_or_LHB_in ? dstReg_in : srcReg1_in;

  // Loads are never forwarded from X/M; the hazard unit stalls load-use.
  assign w_a_xm = r_regwrite && !r_memread && (r_dst == w_src_a) && (w_src_a != '0);
  assign w_a_mw = memwb_regwrite && (memwb_dstReg == w_src_a) && (w_src_a != '0);
  assign w_b_xm = r_regwrite && !r_memread && (r_dst == srcReg2_in) && (srcReg2_in != '0);
  assign w_b_mw = memwb_regwrite && (memwb_dstReg == srcReg2_in) && (srcReg2_in != '0);

  assign w_op_a = w_a_xm ? r_alu_result : (w_a_mw ? memwb_data : rd1_in);
  assign w_op_b = w_b_xm ? r_alu_result : (w_b_mw ? memwb_data : rd2_in);

  alu_16 u_alu (
    .i_opcode       (opcode_in),
    .i_a            (w_op_a),
    .i_b            (w_op_b),
    .i_imm          (sign_ext_in),
    .o_result       (w_result),
    .o_flags        (w_flags),
    .o_flag_wr_mask (w_mask)
  );

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      r_alu_result <= '0;
      r_store_data <= '0;
      r_dst        <= '0;
      r_regwrite   <= 1'b0;
      r_memread    <= 1'b0;
      r_memwrite   <= 1'b0;
    end else if (!stall_en) begin
      r_alu_result <= w_result;
      r_store_data <= w_op_b;
      r_dst        <= dstReg_in;
      r_regwrite   <= regwrite_in;
      r_memread    <= memread_in;
      r_memwrite   <= memwrite_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_flags <= 3'b000;
    end else if (!flush && !stall_en) begin
      r_flags <= (r_flags & ~w_mask) | (w_flags & w_mask);
    end
  end

  assign alu_result_out = r_alu_result;
  assign store_data_out = r_store_data;
  assign dstReg_out     = r_dst;
  assign regwrite_out   = r_regwrite;
  assign memread_out    = r_memread;
  assign memwrite_out   = r_memwrite;
  assign flags_out      = r_flags;
endmodule

// File: tb/tb_execute_stage.sv
// Bench for execute_stage: directed scenarios plus randomized traffic against
// an arithmetic reference model of the EX stage and its X/M register.
module tb_execute_stage;
  logic        clk = 1'b0;
  logic        rst_n, stall_en, flush;
  logic [3:0]  opcode_in;
  logic [15:0] rd1_in, rd2_in, sign_ext_in;
  logic [3:0]  dstReg_in, srcReg1_in, srcReg2_in;
  logic        is_LLB_or_LHB_in, regwrite_in, memread_in, memwrite_in;
  logic        memwb_regwrite;
  logic [3:0]  memwb_dstReg;
  logic [15:0] memwb_data;
  logic [15:0] alu_result_out, store_data_out;
  logic [3:0]  dstReg_out;
  logic        regwrite_out, memread_out, memwrite_out;
  logic [2:0]  flags_out;

  int checks = 0;
  int errors = 0;

  // Reference model state for the X/M register and flags
  logic [15:0] m_res, m_sd;
  logic [3:0]  m_dst;
  logic        m_rw, m_mr, m_mw;
  logic [2:0]  m_flags;

  execute_stage dut (
    .clk(clk), .rst_n(rst_n), .stall_en(stall_en), .flush(flush),
    .opcode_in(opcode_in), .rd1_in(rd1_in), .rd2_in(rd2_in), .sign_ext_in(sign_ext_in),
    .dstReg_in(dstReg_in), .srcReg1_in(srcReg1_in), .srcReg2_in(srcReg2_in),
    .is_LLB_or_LHB_in(is_LLB_or_LHB_in), .regwrite_in(regwrite_in),
    .memread_in(memread_in), .memwrite_in(memwrite_in),
    .memwb_regwrite(memwb_regwrite), .memwb_dstReg(memwb_dstReg), .memwb_data(memwb_data),
    .alu_result_out(alu_result_out), .store_data_out(store_data_out), .dstReg_out(dstReg_out),
    .regwrite_out(regwrite_out), .memread_out(memread_out), .memwrite_out(memwrite_out),
    .flags_out(flags_out)
  );

  always #5 clk = ~clk;

  function automatic void ref_exec(input logic [3:0] op, input logic [15:0] a, b, imm,
                                   output logic [15:0] res, output logic [2:0] fl,
                                   output logic [2:0] msk);
    int s;
    logic sat;
    res = a; msk = 3'b000; sat = 1'b0;
    case (op)
      4'h0, 4'h1: begin
        s = (op == 4'h0) ? int'($signed(a)) + int'($signed(b)) : int'($signed(a)) - int'($signed(b));
        if (s > 32767) begin s = 32767; sat = 1'b1; end
        else if (s < -32768) begin s = -32768; sat = 1'b1; end
        res = s[15:0]; msk = 3'b111;
      end
      4'h2: begin res = a ^ b; msk = 3'b100; end
      4'h3: begin
        s = int'($signed(a[15:8])) + int'($signed(b[15:8])) + int'($signed(a[7:0])) + int'($signed(b[7:0]));
        res = s[15:0];
      end
      4'h4: begin res = a << imm[3:0]; msk = 3'b100; end
      4'h5: begin s = int'($signed(a)) >>> imm[3:0]; res = s[15:0]; msk = 3'b100; end
      4'h6: begin
        for (int k = 0; k < int'(imm[3:0]); k++) res = {res[0], res[15:1]};
        msk = 3'b100;
      end
      4'h7: begin
        for (int n = 0; n < 4; n++) begin
          int na, nb;
          na = int'(a[4*n +: 4]); nb = int'(b[4*n +: 4]);
          if (na > 7) na -= 16;
          if (nb > 7) nb -= 16;
          s = na + nb;
          if (s > 7) s = 7; else if (s < -8) s = -8;
          res[4*n +: 4] = s[3:0];
        end
      end
      4'h8, 4'h9: begin s = int'(a & 16'hFFFE) + 2 * int'(imm); res = s[15:0]; end
      4'hA: res = {imm[7:0], a[7:0]};
      4'hB: res = {a[15:8], imm[7:0]};
      default: res = a;
    endcase
    fl = {res == 16'h0000, sat, res[15]};
  endfunction

  function automatic logic [15:0] fwd(input logic [3:0] src, input logic [15:0] dx);
    if (src != 4'd0 && m_rw && !m_mr && m_dst == src) return m_res;
    if (src != 4'd0 && memwb_regwrite && memwb_dstReg == src) return memwb_data;
    return dx;
  endfunction

  // Advance one clock, updating the model from the inputs currently driven.
  task automatic tick();
    logic [15:0] a, b, res;
    logic [2:0]  fl, msk;
    a = fwd(srcReg1_in, rd1_in);
    b = fwd(srcReg2_in, rd2_in);
    ref_exec(opcode_in, a, b, sign_ext_in, res, fl, msk);
    @(posedge clk);
    if (!rst_n || flush) begin
      m_res = '0; m_sd = '0; m_dst = '0; m_rw = 0; m_mr = 0; m_mw = 0;
    end else if (!stall_en) begin
      m_res = res; m_sd = b; m_dst = dstReg_in; m_rw = regwrite_in; m_mr = memread_in; m_mw = memwrite_in;
    end
    if (!rst_n) m_flags = 3'b000;
    else if (!flush && !stall_en) m_flags = (m_flags & ~msk) | (fl & msk);
    #1;
  endtask

  task automatic set_op(input logic [3:0] op, input logic [15:0] r1, r2, imm,
                        input logic [3:0] d, s1, s2, input logic rw, mr, mw);
    opcode_in = op; rd1_in = r1; rd2_in = r2; sign_ext_in = imm;
    dstReg_in = d; srcReg1_in = s1; srcReg2_in = s2;
    regwrite_in = rw; memread_in = mr; memwrite_in = mw;
    is_LLB_or_LHB_in = (op == 4'hA || op == 4'hB);
  endtask

  task automatic test_reset();
    rst_n = 0; stall_en = 0; flush = 0;
    memwb_regwrite = 1; memwb_dstReg = 4'd2; memwb_data = 16'hAAAA;
    set_op(4'h0, 16'h1111, 16'h2222, 16'h0003, 4'd1, 4'd2, 4'd3, 1, 1, 1);
    tick();
    checks++;
    if ({alu_result_out, store_data_out, dstReg_out, regwrite_out, memread_out, memwrite_out, flags_out} !== '0) begin
      errors++;
      $display("FAIL reset: got res=%h sd=%h dst=%h ctl=%b%b%b fl=%b, want all zero",
               alu_result_out, store_data_out, dstReg_out, regwrite_out, memread_out, memwrite_out, flags_out);
    end
    rst_n = 1; memwb_regwrite = 0;
  endtask

  task automatic test_add_sub();
    set_op(4'h0, 16'h7000, 16'h2000, 16'h0, 4'd1, 4'd2, 4'd3, 1, 0, 0);
    tick();
    checks++;
    if (alu_result_out !== 16'h7FFF || flags_out !== 3'b010) begin
      errors++; $display("FAIL add_sat: got %h fl=%b, want 7fff fl=010", alu_result_out, flags_out);
    end
    set_op(4'h1, 16'h0005, 16'h0005, 16'h0, 4'd2, 4'd4, 4'd5, 1, 0, 0);
    tick();
    checks++;
    if (alu_result_out !== 16'h0000 || flags_out !== 3'b100) begin
      errors++; $display("FAIL sub_zero: got %h fl=%b, want 0000 fl=100", alu_result_out, flags_out);
    end
  endtask

  task automatic test_forwarding();
    set_op(4'h0, 16'h1000, 16'h0234, 16'h0, 4'd1, 4'd2, 4'd3, 1, 0, 0);
    tick();
    set_op(4'h2, 16'h1234, 16'h5678, 16'h0, 4'd4, 4'd1, 4'd1, 1, 0, 0);
    tick();
    checks++;
    if (alu_result_out !== 16'h0000 || flags_out !== 3'b100) begin
      errors++; $display("FAIL fwd_xm: got %h fl=%b, want 0000 fl=100", alu_result_out, flags_out);
    end
    // Writer two ahead: R1's value now arrives from the M/W stage.
    set_op(4'h0, 16'h0001, 16'h0001, 16'h0, 4'd6, 4'd7, 4'd7, 1, 0, 0);
    tick();
    memwb_regwrite = 1; memwb_dstReg = 4'd1; memwb_data = 16'h0300;
    set_op(4'h1, 16'h7777, 16'h0100, 16'h0, 4'd4, 4'd1, 4'd2, 1, 0, 0);
    tick();
    memwb_regwrite = 0;
    checks++;
    if (alu_result_out !== 16'h0200 || store_data_out !== 16'h0100) begin
      errors++; $display("FAIL fwd_mw: got %h sd=%h, want 0200 sd=0100", alu_result_out, store_data_out);
    end
  endtask

  task automatic test_priority();
    set_op(4'h0, 16'h0111, 16'h0000, 16'h0, 4'd5, 4'd8, 4'd0, 1, 0, 0);
    tick();
    memwb_regwrite = 1; memwb_dstReg = 4'd5; memwb_data = 16'h4444;
    set_op(4'h0, 16'h0EEE, 16'h0009, 16'h0, 4'd7, 4'd5, 4'd0, 1, 0, 0);
    tick();
    checks++;
    if (alu_result_out !== 16'h011A) begin
      errors++; $display("FAIL fwd_priority: got %h, want 011a", alu_result_out);
    end
    memwb_regwrite = 0;
    set_op(4'h0, 16'h0050, 16'h0000, 16'h0, 4'd0, 4'd9, 4'd0, 1, 0, 0);
    tick();
    memwb_regwrite = 1; memwb_dstReg = 4'd0; memwb_data = 16'h1000;
    set_op(4'h0, 16'h0001, 16'h0001, 16'h0, 4'd8, 4'd0, 4'd0, 1, 0, 0);
    tick();
    memwb_regwrite = 0;
    checks++;
    if (alu_result_out !== 16'h0002) begin
      errors++; $display("FAIL r0_no_fwd: got %h, want 0002", alu_result_out);
    end
  endtask

  task automatic test_llb_lhb();
    logic [2:0] fl_before;
    fl_before = m_flags;
    set_op(4'hB, 16'h1234, 16'h0000, 16'h00AB, 4'd3, 4'd3, 4'd0, 1, 0, 0);
    tick();
    checks++;
    if (alu_result_out !== 16'h12AB || flags_out !== fl_before) begin
      errors++; $display("FAIL llb: got %h fl=%b, want 12ab fl=%b", alu_result_out, flags_out, fl_before);
    end
    set_op(4'hA, 16'h0000, 16'h0000, 16'h00CD, 4'd3, 4'd3, 4'd0, 1, 0, 0);
    tick();
    checks++;
    if (alu_result_out !== 16'hCDAB || flags_out !== fl_before) begin
      errors++; $display("FAIL lhb: got %h fl=%b, want cdab fl=%b", alu_result_out, flags_out, fl_before);
    end
  endtask

  task automatic test_paddsb_sw();
    set_op(4'h7, 16'h7788, 16'h1111, 16'h0, 4'd9, 4'd10, 4'd11, 1, 0, 0);
    tick();
    checks++;
    if (alu_result_out !== 16'h7799) begin
      errors++; $display("FAIL paddsb: got %h, want 7799", alu_result_out);
    end
    set_op(4'h9, 16'h1001, 16'hBEEF, 16'h0003, 4'd0, 4'd12, 4'd13, 0, 0, 1);
    tick();
    checks++;
    if (alu_result_out !== 16'h1006 || store_data_out !== 16'hBEEF || {regwrite_out, memwrite_out} !== 2'b01) begin
      errors++; $display("FAIL sw_addr: got %h sd=%h rw/mw=%b%b, want 1006 sd=beef rw/mw=01",
                         alu_result_out, store_data_out, regwrite_out, memwrite_out);
    end
  endtask

  task automatic test_stall_flush();
    set_op(4'h0, 16'h7000, 16'h2000, 16'h0, 4'd1, 4'd2, 4'd3, 1, 0, 0);
    tick();
    stall_en = 1;
    set_op(4'h1, 16'h0005, 16'h0005, 16'h0, 4'd2, 4'd12, 4'd13, 1, 0, 0);
    for (int k = 0; k < 3; k++) tick();
    checks++;
    if (alu_result_out !== 16'h7FFF || dstReg_out !== 4'd1 || flags_out !== 3'b010) begin
      errors++; $display("FAIL stall_hold: got %h dst=%h fl=%b, want 7fff dst=1 fl=010",
                         alu_result_out, dstReg_out, flags_out);
    end
    flush = 1;
    tick();
    checks++;
    if ({alu_result_out, store_data_out, dstReg_out, regwrite_out, memread_out, memwrite_out} !== '0
        || flags_out !== 3'b010) begin
      errors++; $display("FAIL flush_bubble: got %h sd=%h dst=%h rw=%b fl=%b, want zero bubble fl=010",
                         alu_result_out, store_data_out, dstReg_out, regwrite_out, flags_out);
    end
    flush = 0;
    tick();
    rst_n = 0;
    tick();
    checks++;
    if ({alu_result_out, store_data_out, dstReg_out, regwrite_out, memread_out, memwrite_out, flags_out} !== '0) begin
      errors++; $display("FAIL reset_in_stall: got %h dst=%h fl=%b, want all zero", alu_result_out, dstReg_out, flags_out);
    end
    rst_n = 1; stall_en = 0;
  endtask

  task automatic test_random();
    logic [3:0] op, d;
    for (int it = 0; it < 400; it++) begin
      op = 4'($urandom_range(0, 15));
      d  = 4'($urandom_range(0, 3));
      set_op(op, 16'($urandom), 16'($urandom), 16'($urandom), d,
             (op == 4'hA || op == 4'hB) ? d : 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
             1'($urandom), 1'($urandom_range(0, 3) == 0), 1'($urandom));
      memwb_regwrite = 1'($urandom); memwb_dstReg = 4'($urandom_range(0, 3)); memwb_data = 16'($urandom);
      stall_en = ($urandom_range(0, 9) == 0);
      flush    = ($urandom_range(0, 9) == 0);
      tick();
      checks++;
      if ({alu_result_out, store_data_out, dstReg_out, regwrite_out, memread_out, memwrite_out, flags_out}
          !== {m_res, m_sd, m_dst, m_rw, m_mr, m_mw, m_flags}) begin
        errors++;
        $display("FAIL random[%0d] op=%h: got res=%h sd=%h dst=%h ctl=%b%b%b fl=%b, want res=%h sd=%h dst=%h ctl=%b%b%b fl=%b",
                 it, op, alu_result_out, store_data_out, dstReg_out, regwrite_out, memread_out, memwrite_out, flags_out,
                 m_res, m_sd, m_dst, m_rw, m_mr, m_mw, m_flags);
      end
    end
    stall_en = 0; flush = 0; memwb_regwrite = 0;
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_forwarding();
    test_priority();
    test_llb_lhb();
    test_paddsb_sw();
    test_stall_flush();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
